bcd_down_counter: RTL

//   Multi-digit BCD down-counter (countdown timer), the decrementing counterpart of
//   the decimal up-counter. Loads a BCD start value, counts down one per enabled

---
 rtl/bcd_down_pkg.sv | 16 +
 rtl/bcd_down_digit.sv | 26 ++
 rtl/bcd_down_counter.sv | 110 +++++++++++
 3 files changed

// File: rtl/bcd_down_pkg.sv
// Shared decade width, state encoding and load clamp for the BCD down-counter.
package bcd_down_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibbles above 9 are not legal BCD; saturate them on load.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// Single-decade BCD decrement: 0 with borrow-in wraps to 9 and borrows onward.
// Latency: combinational.
// Backpressure: none.
module bcd_down_digit
  import bcd_down_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  always_comb begin
    q          = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == '0) begin
        q          = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        q = d - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with terminal-count pulse; BCD_DOWN_AUTORELOAD_EN restarts from the loaded value.
// Latency: 1 clk per enabled decrement; done is registered and trails the terminal tick by one edge.
// Backpressure: none; enable qualifies counting, load overrides everything except reset.
module bcd_down_counter
  import bcd_down_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    enable,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    zero,
  output logic                    done,
  output logic                    busy
);

  localparam int CW = BCD_W * DIGITS;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_d;
  logic [CW-1:0]   count_dec;
  logic [CW-1:0]   load_clamped;
  logic [DIGITS:0] borrow;
  logic            done_d;
`ifdef BCD_DOWN_AUTORELOAD_EN
  logic [CW-1:0]   reload_q, reload_d;
`endif

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped[g*BCD_W +: BCD_W] = clamp_digit(load_val[g*BCD_W +: BCD_W]);

    bcd_down_digit u_digit (
      .d          (count[g*BCD_W +: BCD_W]),
      .borrow_in  (borrow[g]),
      .q          (count_dec[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  // A borrow rippling out of the top decade means every digit was zero.
  assign zero = borrow[DIGITS];
  assign busy = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    count_d = count;
    done_d  = 1'b0;
`ifdef BCD_DOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = load_clamped;
      state_d = ST_IDLE;
`ifdef BCD_DOWN_AUTORELOAD_EN
      reload_d = load_clamped;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (enable) begin
            if (count == ONE) begin
              count_d = '0;
              done_d  = 1'b1;
`ifndef BCD_DOWN_AUTORELOAD_EN
              state_d = ST_DONE;
`endif
            end else if (!zero) begin
              count_d = count_dec;
            end
`ifdef BCD_DOWN_AUTORELOAD_EN
            else begin
              count_d = reload_q;
            end
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count   <= '0;
      done    <= 1'b0;
`ifdef BCD_DOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count   <= count_d;
      done    <= done_d;
`ifdef BCD_DOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

endmodule
